store_ctrl: RTL and testbench

STORE_CTRL -- requirements
Module: store_ctrl

---
 rtl/store_ctrl.sv | 177 +++++++++++++++++
 tb/tb_store_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_ctrl.sv
// rtl/store_ctrl.sv - RISC-V S-type store controller; optional misalignment trap via STORE_MISALIGN_TRAP_EN
module store_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [2:0]  funct3,
   input  logic [4:0]  instrn11_7,
   input  logic [6:0]  instrn31_25,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   output logic        st_done,
   output logic        st_err,
   output logic [1:0]  st_err_code
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
   localparam logic [1:0] ERR_MISALIGN = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic        load;

   logic [11:0] imm12;
   logic [31:0] ea;
   logic [31:0] addr_n, wdata_n;
   logic [3:0]  be_n;
   logic        illegal;
   logic        misalign_trap;
   logic        accept;

   assign imm12  = {instrn31_25, instrn11_7};
   assign ea     = rs1_val + {{20{imm12[11]}}, imm12};
   assign addr_n = {ea[31:2], 2'b00};
   assign accept = st_valid & (state_q == S_IDLE);

   // Lane placement of the store data and byte enables from width and address offset
   always_comb begin
      be_n    = 4'b0000;
      wdata_n = 32'h0;
      illegal = 1'b0;
      case (funct3)
         3'b000: begin
            be_n    = 4'b0001 << ea[1:0];
            wdata_n = {4{rs2_val[7:0]}};
         end
         3'b001: begin
            be_n    = 4'b0011 << {ea[1], 1'b0};
            wdata_n = {2{rs2_val[15:0]}};
         end
         3'b010: begin
            be_n    = 4'b1111;
            wdata_n = rs2_val;
         end
         default: illegal = 1'b1;
      endcase
   end

`ifdef STORE_MISALIGN_TRAP_EN
   assign misalign_trap = ((funct3 == 3'b001) && ea[0]) ||
                          ((funct3 == 3'b010) && (ea[1:0] != 2'b00));
`else
   assign misalign_trap = 1'b0;
`endif

   // Next-state, ack/timeout counter and completion pulse decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               load  = 1'b1;
               cnt_d = 8'd0;
               if (illegal) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  code_d  = ERR_ILLEGAL;
               end else if (misalign_trap) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
                  code_d  = ERR_MISALIGN;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_RESP;
               done_d  = 1'b1;
               cnt_d   = 8'd0;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_RESP;
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // State, counter and registered completion pulses
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   // Write beat captured on accept and held until the next accept
   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'b0000;
      end else if (load) begin
         addr_q  <= addr_n;
         wdata_q <= wdata_n;
         be_q    <= be_n;
      end
   end

   assign st_ready    = (state_q == S_IDLE);
   assign mem_req     = (state_q == S_REQ);
   assign mem_addr    = addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_be      = be_q;
   assign st_done     = done_q;
   assign st_err      = err_q;
   assign st_err_code = code_q;

endmodule

// File: tb/tb_store_ctrl.sv
// tb/tb_store_ctrl.sv - self-checking bench for store_ctrl with per-cycle scoreboard
module tb_store_ctrl;

   localparam int T = 15;

   logic        clk;
   logic        rstn;
   logic        st_valid;
   logic        st_ready;
   logic [2:0]  funct3;
   logic [4:0]  instrn11_7;
   logic [6:0]  instrn31_25;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        st_done;
   logic        st_err;
   logic [1:0]  st_err_code;

   store_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rstn(rstn), .st_valid(st_valid), .st_ready(st_ready),
      .funct3(funct3), .instrn11_7(instrn11_7), .instrn31_25(instrn31_25),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_ack(mem_ack), .st_done(st_done), .st_err(st_err),
      .st_err_code(st_err_code)
   );

   typedef struct {
      bit          ready;
      bit          req;
      bit          done;
      bit          err;
      logic [1:0]  code;
      bit          chk_bus;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(bit ready, bit req, bit done, bit err, logic [1:0] code,
                               bit chk, logic [31:0] addr, logic [31:0] wdata,
                               logic [3:0] be, string tag);
      exp_t e;
      e.ready = ready; e.req = req; e.done = done; e.err = err; e.code = code;
      e.chk_bus = chk; e.addr = addr; e.wdata = wdata; e.be = be; e.tag = tag;
      return e;
   endfunction

   // Reference: byte-lane view of a store (size bytes placed at an offset, data repeated)
   task automatic model(input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] rs1,
                        input logic [31:0] rs2, output bit legal, output bit trap,
                        output logic [31:0] addr, output logic [31:0] wdata,
                        output logic [3:0] be);
      int size;
      int off;
      int signed simm;
      logic [31:0] ea;
      simm  = (imm >= 12'h800) ? int'(imm) - 4096 : int'(imm);
      ea    = rs1 + 32'(simm);
      legal = (f3 <= 3'd2);
      size  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      off   = (size == 1) ? int'(ea % 4) : (size == 2) ? int'(ea % 4) / 2 * 2 : 0;
      addr  = ea - (ea % 4);
      trap  = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      trap  = legal && (size > 1) && ((ea % size) != 0);
`endif
      be    = 4'b0000;
      wdata = 32'h0;
      for (int j = 0; j < 4; j++) begin
         be[j]          = (j >= off) && (j < off + size);
         wdata[8*j +: 8] = rs2[8*(j % size) +: 8];
      end
   endtask

   task automatic cyc(input exp_t e);
      @(negedge clk);
      exp_q.push_back(e);
   endtask

   task automatic garble();
      st_valid    = 1'b0;
      funct3      = 3'($urandom);
      instrn11_7  = 5'($urandom);
      instrn31_25 = 7'($urandom);
      rs1_val     = $urandom;
      rs2_val     = $urandom;
   endtask

   task automatic present(input logic [2:0] f3, input logic [11:0] imm,
                          input logic [31:0] rs1, input logic [31:0] rs2);
      st_valid    = 1'b1;
      funct3      = f3;
      instrn31_25 = imm[11:5];
      instrn11_7  = imm[4:0];
      rs1_val     = rs1;
      rs2_val     = rs2;
      mem_ack     = 1'($urandom);
   endtask

   // ackat: REQ cycle index carrying mem_ack (0 = first), negative = never
   task automatic store(input logic [2:0] f3, input logic [11:0] imm, input logic [31:0] rs1,
                        input logic [31:0] rs2, input int ackat, input bit lit,
                        input logic [31:0] laddr, input logic [31:0] lwdata,
                        input logic [3:0] lbe, input string tag);
      bit legal, trap;
      logic [31:0] a, w;
      logic [3:0] b;
      int n;
      model(f3, imm, rs1, rs2, legal, trap, a, w, b);
      if (lit) begin
         a = laddr; w = lwdata; b = lbe;
      end
      cyc(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, {tag, "_idle"}));
      present(f3, imm, rs1, rs2);
      if (!legal || trap) begin
         cyc(mk(0, 0, 0, 1, legal ? 2'b10 : 2'b01, 0, 0, 0, 0, {tag, "_err"}));
         garble();
         mem_ack = 1'($urandom);
         return;
      end
      n = (ackat < 0) ? T : ackat + 1;
      for (int i = 0; i < n; i++) begin
         cyc(mk(0, 1, 0, 0, 2'b00, 1, a, w, b, {tag, "_req"}));
         garble();
         mem_ack = (i == ackat);
      end
      if (ackat < 0)
         cyc(mk(0, 0, 0, 1, 2'b11, 0, 0, 0, 0, {tag, "_timeout"}));
      else
         cyc(mk(0, 0, 1, 0, 2'b00, 0, 0, 0, 0, {tag, "_done"}));
      mem_ack = 1'($urandom);
   endtask

   // Compare DUT outputs with the scoreboard mid-cycle
   initial begin
      exp_t e;
      bit bad;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            bad = (st_ready !== e.ready) || (mem_req !== e.req) || (st_done !== e.done) ||
                  (st_err !== e.err) || (st_err_code !== e.code);
            if (e.chk_bus)
               bad = bad || (mem_addr !== e.addr) || (mem_wdata !== e.wdata) || (mem_be !== e.be);
            if (bad) begin
               miscompares++;
               $display("FAIL %s: got rdy=%b req=%b done=%b err=%b code=%b addr=%h wd=%h be=%b, want rdy=%b req=%b done=%b err=%b code=%b addr=%h wd=%h be=%b",
                        e.tag, st_ready, mem_req, st_done, st_err, st_err_code, mem_addr,
                        mem_wdata, mem_be, e.ready, e.req, e.done, e.err, e.code, e.addr,
                        e.wdata, e.be);
            end
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      mem_ack     = 1'b0;
      garble();

      cyc(mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, "reset0"));
      cyc(mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, "reset1"));
      rstn = 1'b1;
      cyc(mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, "post_reset"));
      mem_ack = 1'b1;

      store(3'b010, 12'h004, 32'h1000, 32'hDEADBEEF, 0, 1, 32'h1004, 32'hDEADBEEF, 4'b1111, "sw_basic");
      store(3'b000, 12'hFFF, 32'h2000, 32'h000000A5, 1, 1, 32'h1FFC, 32'hA5A5A5A5, 4'b1000, "sb_neg");
`ifdef STORE_MISALIGN_TRAP_EN
      store(3'b001, 12'h003, 32'h3000, 32'h1234BEEF, 0, 0, 0, 0, 0, "sh_mis");
`else
      store(3'b001, 12'h003, 32'h3000, 32'h1234BEEF, 0, 1, 32'h3000, 32'hBEEFBEEF, 4'b1100, "sh_mis");
`endif
      store(3'b010, 12'h000, 32'h4000, 32'h11223344, -1, 0, 0, 0, 0, "sw_timeout");
      store(3'b010, 12'h010, 32'h4000, 32'h55667788, T - 1, 0, 0, 0, 0, "ack_last");
      store(3'b010, 12'h7FC, 32'h0, 32'hCAFEF00D, T - 2, 1, 32'h000007FC, 32'hCAFEF00D, 4'b1111, "ack_prelast");
      store(3'b011, 12'h000, 32'h5000, 32'h0, 0, 0, 0, 0, 0, "illegal3");
      store(3'b111, 12'h000, 32'h5000, 32'h0, 0, 0, 0, 0, 0, "illegal7");
      store(3'b001, 12'hFFE, 32'h44, 32'hABCD1234, 2, 1, 32'h40, 32'h12341234, 4'b1100, "sh_up");
      store(3'b010, 12'h001, 32'hFFFFFFFF, 32'h0BADF00D, 0, 0, 0, 0, 0, "sw_wrap");
      for (int k = 0; k < 4; k++)
         store(3'b000, 12'(k), 32'h8000, 32'h100 + 32'(k * 17), k, 0, 0, 0, 0, "sb_lane");

      // Reset in the third REQ cycle, then a clean store
      cyc(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, "rst_idle"));
      present(3'b010, 12'h008, 32'h6000, 32'h01020304);
      for (int i = 0; i < 3; i++) begin
         cyc(mk(0, 1, 0, 0, 2'b00, 1, 32'h6008, 32'h01020304, 4'b1111, "rst_req"));
         garble();
         mem_ack = 1'b0;
      end
      rstn    = 1'b0;
      mem_ack = 1'b1;
      cyc(mk(1, 0, 0, 0, 2'b00, 1, 0, 0, 0, "rst_mid"));
      rstn    = 1'b1;
      mem_ack = 1'b0;
      store(3'b010, 12'h00C, 32'h6000, 32'h0A0B0C0D, 0, 1, 32'h600C, 32'h0A0B0C0D, 4'b1111, "after_rst");

      cyc(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, "final_idle"));
      cyc(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, "final_idle2"));
      @(negedge clk);
      #5;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
